// File: rtl/wb_pkg.sv
// wb_pkg: load-type encodings and sub-word load extraction for the write-back stage.
package wb_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    LT_W  = 3'd0,
    LT_B  = 3'd1,
    LT_BU = 3'd2,
    LT_H  = 3'd3,
    LT_HU = 3'd4
  } load_t;
  // Little-endian lane select; bit 0 of the offset is ignored for halfwords.
  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] lt, input logic [1:0] off,
                                               input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    return lt == LT_B  ? {{24{b[7]}}, b} :
           lt == LT_BU ? {24'b0, b} :
           lt == LT_H  ? {{16{h[15]}}, h} :
           lt == LT_HU ? {16'b0, h} : word;
  endfunction
endpackage

// File: rtl/wb_queue.sv
// wb_queue: small synchronous FIFO; push is ignored when full and pop when empty.
module wb_queue #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rp_q];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, load extraction and register-file write port shared
// between the in-order pipeline and a queue of long-latency unit results.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int Q_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_mem,
  input  logic              MemtoReg_mem,
  input  logic [2:0]        LoadType_mem,
  input  logic [ADDR_W-1:0] RegWriteAddr_mem,
  input  logic [DATA_W-1:0] ALUResult_mem,
  input  logic [DATA_W-1:0] MemData_mem,
  input  logic              LongValid,
  input  logic [ADDR_W-1:0] LongAddr,
  input  logic [DATA_W-1:0] LongData,
  output logic              LongReady,
  output logic              WB_StallReq,
  output logic              RegWrite_wb,
  output logic [ADDR_W-1:0] RegWriteAddr_wb,
  output logic [DATA_W-1:0] RegWriteData_wb
);
  logic              rw_q, m2r_q;
  logic [2:0]        lt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] alu_q, md_q;
  logic [ADDR_W+DATA_W-1:0] head;
  logic              q_full, q_empty, q_push, q_pop, pipe_wr;
  logic [DATA_W-1:0] pipe_res;
  // A full queue forces a bubble into WB so the head can drain next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q   <= 1'b0;
      m2r_q  <= 1'b0;
      lt_q   <= '0;
      addr_q <= '0;
      alu_q  <= '0;
      md_q   <= '0;
    end else begin
      rw_q   <= RegWrite_mem && !q_full;
      m2r_q  <= MemtoReg_mem;
      lt_q   <= LoadType_mem;
      addr_q <= RegWriteAddr_mem;
      alu_q  <= ALUResult_mem;
      md_q   <= MemData_mem;
    end
  end
  assign pipe_res = m2r_q ? load_ext(lt_q, alu_q[1:0], md_q) : alu_q;
  assign pipe_wr  = rw_q && addr_q != '0;
  assign q_pop    = !pipe_wr && !q_empty;
  assign q_push   = LongValid && !q_full && LongAddr != '0;
  assign LongReady   = !q_full;
  assign WB_StallReq = q_full;
  always_comb begin
    RegWrite_wb     = pipe_wr || !q_empty;
    RegWriteAddr_wb = q_pop ? head[ADDR_W+DATA_W-1:DATA_W] : addr_q;
    RegWriteData_wb = q_pop ? head[DATA_W-1:0] : pipe_res;
  end
  wb_queue #(.W(ADDR_W+DATA_W), .DEPTH(Q_DEPTH)) u_queue (
    .clk    (clk),
    .reset  (reset),
    .push_i (q_push),
    .pop_i  (q_pop),
    .din_i  ({LongAddr, LongData}),
    .head_o (head),
    .full_o (q_full),
    .empty_o(q_empty)
  );
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and random stimulus against a queue-based reference model of the write-back port.
module tb_wb_stage;
  import wb_pkg::*;
  localparam int QD = 2;
  logic        clk = 1'b0, reset = 1'b1;
  logic        RegWrite_mem = 0, MemtoReg_mem = 0, LongValid = 0;
  logic [2:0]  LoadType_mem = 0;
  logic [4:0]  RegWriteAddr_mem = 0, LongAddr = 0, RegWriteAddr_wb;
  logic [31:0] ALUResult_mem = 0, MemData_mem = 0, LongData = 0, RegWriteData_wb;
  logic        LongReady, WB_StallReq, RegWrite_wb;
  always #5 clk = ~clk;
  wb_stage #(.DATA_W(32), .ADDR_W(5), .Q_DEPTH(QD)) dut (
    .clk(clk), .reset(reset), .RegWrite_mem(RegWrite_mem), .MemtoReg_mem(MemtoReg_mem),
    .LoadType_mem(LoadType_mem), .RegWriteAddr_mem(RegWriteAddr_mem), .ALUResult_mem(ALUResult_mem),
    .MemData_mem(MemData_mem), .LongValid(LongValid), .LongAddr(LongAddr), .LongData(LongData),
    .LongReady(LongReady), .WB_StallReq(WB_StallReq), .RegWrite_wb(RegWrite_wb),
    .RegWriteAddr_wb(RegWriteAddr_wb), .RegWriteData_wb(RegWriteData_wb)
  );
  typedef struct {bit rw; bit m2r; bit [2:0] lt; bit [4:0] a; bit [31:0] alu; bit [31:0] md;} slot_t;
  typedef struct {bit [4:0] a; bit [31:0] d;} lr_t;
  slot_t s = '{default: 0};
  lr_t   q[$];
  int    vec = 0, err = 0;
  bit    acc;
  function automatic bit [31:0] ext(slot_t x);
    bit [31:0] v;
    v = x.md;
    if (x.lt == LT_B || x.lt == LT_BU) begin
      v = (x.md >> (8 * x.alu[1:0])) & 32'hFF;
      if (x.lt == LT_B && v >= 32'd128) v = v - 32'd256;
    end else if (x.lt == LT_H || x.lt == LT_HU) begin
      v = (x.md >> (16 * x.alu[1])) & 32'hFFFF;
      if (x.lt == LT_H && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic pipe(bit rw, bit m2r, logic [2:0] lt, logic [4:0] a, logic [31:0] alu, logic [31:0] md);
    RegWrite_mem = rw; MemtoReg_mem = m2r; LoadType_mem = lt;
    RegWriteAddr_mem = a; ALUResult_mem = alu; MemData_mem = md;
  endtask
  task automatic long(bit v, logic [4:0] a, logic [31:0] d);
    LongValid = v; LongAddr = a; LongData = d;
  endtask
  // Check outputs against the model at the negedge, then advance the model over the next rising edge.
  task automatic step(bit dchk = 0, logic [31:0] dexp = 0);
    bit pw, full;
    bit [31:0] res;
    @(negedge clk);
    res  = s.m2r ? ext(s) : s.alu;
    pw   = s.rw && s.a != 0;
    full = q.size() == QD;
    chk("ready", 32'(LongReady), 32'(!full));
    chk("stall", 32'(WB_StallReq), 32'(full));
    chk("we", 32'(RegWrite_wb), 32'(pw || q.size() > 0));
    chk("waddr", 32'(RegWriteAddr_wb), 32'((!pw && q.size() > 0) ? q[0].a : s.a));
    chk("wdata", RegWriteData_wb, (!pw && q.size() > 0) ? q[0].d : res);
    if (dchk) chk("spec_data", RegWriteData_wb, dexp);
    acc = LongValid && !full && !reset;
    if (reset) begin
      q.delete();
      s = '{default: 0};
    end else begin
      if (!pw && q.size() > 0) void'(q.pop_front());
      if (acc && LongAddr != 0) q.push_back('{LongAddr, LongData});
      s = '{RegWrite_mem && !full, MemtoReg_mem, LoadType_mem, RegWriteAddr_mem, ALUResult_mem, MemData_mem};
    end
    @(posedge clk); #1;
  endtask
  initial begin
    int sent;
    long(1, 5'd3, 32'h77);
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 0;
    long(0, 0, 0);
    step();
    // sub-word loads
    pipe(1, 1, LT_B, 5'd3, 32'h1003, 32'h80FF_0011);
    step();
    pipe(1, 1, LT_HU, 5'd4, 32'h1003, 32'h80FF_0011);
    step(1, 32'hFFFF_FF80);
    pipe(0, 0, LT_W, 0, 0, 0);
    step(1, 32'h0000_80FF);
    // long result waits for a pipeline gap
    pipe(1, 0, LT_W, 5'd5, 32'h1234, 0);
    long(1, 5'd9, 32'hBEEF);
    step();
    long(0, 0, 0);
    repeat (3) step();
    pipe(0, 0, LT_W, 5'd5, 32'h1234, 0);
    repeat (2) step();
    // queue fills, stall bubble drains the oldest entry
    pipe(1, 0, LT_W, 5'd12, 32'h55, 0);
    sent = 0;
    for (int c = 0; c < 20 && sent < 3; c++) begin
      long(1, 5'(20 + sent), 32'hA000 + 32'(sent));
      step();
      if (acc) sent++;
    end
    chk("t4_sent", 32'(sent), 32'd3);
    long(0, 0, 0);
    repeat (3) step();
    pipe(0, 0, LT_W, 0, 0, 0);
    repeat (4) step();
    // writes to r0
    pipe(1, 0, LT_W, 5'd0, 32'h99, 0);
    long(1, 5'd7, 32'h7777);
    step();
    long(1, 5'd0, 32'hDEAD);
    step();
    long(0, 0, 0);
    repeat (3) step();
    // steady push+pop with one entry queued, then reset with entries pending
    pipe(0, 0, LT_W, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      long(1, 5'(8 + i), 32'hC0 + 32'(i));
      step();
    end
    pipe(1, 0, LT_W, 5'd2, 32'h22, 0);
    repeat (3) step();
    reset = 1;
    step();
    reset = 0;
    long(0, 0, 0);
    repeat (2) step();
    // random
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom % 60) == 0;
      pipe($urandom % 3 != 0, $urandom % 2 == 1, 3'($urandom_range(0, 4)),
           ($urandom % 4 == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
      long($urandom % 2 == 1, ($urandom % 5 == 0) ? 5'd0 : 5'($urandom), $urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
